// File: rtl/mux_sel_scanner.sv
// Round-robin select sequencer and sampler for a 4:1 single-bit mux.
// Steps sel across the enabled channels, holds each for a programmable dwell,
// samples y at the end of each dwell and assembles the samples into a frame word.
module mux_sel_scanner #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               single_shot,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               y,
    output logic [1:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               sample_stb,
    output logic               sample_bit,
    output logic [1:0]         sample_ch,
    output logic [3:0]         frame,
    output logic               frame_done
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 when none is set (callers check for zero first).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NCH-1:0] m);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

    state_t               r_state;
    state_t               w_state_nx;
    logic [NCH-1:0]       r_mask_q;
    logic [NCH-1:0]       w_mask_q_nx;
    logic [DWELL_W-1:0]   r_dwell_q;
    logic [DWELL_W-1:0]   w_dwell_q_nx;
    logic [DWELL_W-1:0]   r_cnt;
    logic [DWELL_W-1:0]   w_cnt_nx;
    logic [NCH-1:0]       r_acc;
    logic [NCH-1:0]       w_acc_nx;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     w_sel_nx;
    logic                 r_sel_valid;
    logic                 w_sel_valid_nx;
    logic                 r_busy;
    logic                 w_busy_nx;
    logic                 r_sample_stb;
    logic                 w_sample_stb_nx;
    logic                 r_sample_bit;
    logic                 w_sample_bit_nx;
    logic [SEL_W-1:0]     r_sample_ch;
    logic [SEL_W-1:0]     w_sample_ch_nx;
    logic [NCH-1:0]       r_frame;
    logic [NCH-1:0]       w_frame_nx;
    logic                 r_frame_done;
    logic                 w_frame_done_nx;

    logic [DWELL_W-1:0]   w_dwell_eff;
    logic [NCH-1:0]       w_above;
    logic [NCH-1:0]       w_acc_merged;
    logic                 w_last_cycle;
    logic                 w_start_ok;

    // Helper decodes: effective dwell, channels above the current one, end-of-dwell.
    always_comb begin
        w_dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
        w_above      = r_mask_q & NCH'(4'b1110 << r_sel);
        w_last_cycle = (r_cnt == (r_dwell_q - DWELL_W'(1)));
        w_start_ok   = en && (mask != '0);
        w_acc_merged = r_acc;
        w_acc_merged[r_sel] = y;
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx      = r_state;
        w_mask_q_nx     = r_mask_q;
        w_dwell_q_nx    = r_dwell_q;
        w_cnt_nx        = r_cnt;
        w_acc_nx        = r_acc;
        w_sel_nx        = r_sel;
        w_sel_valid_nx  = 1'b0;
        w_busy_nx       = 1'b0;
        w_sample_stb_nx = 1'b0;
        w_sample_bit_nx = r_sample_bit;
        w_sample_ch_nx  = r_sample_ch;
        w_frame_nx      = r_frame;
        w_frame_done_nx = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nx     = ST_DWELL;
                    w_mask_q_nx    = mask;
                    w_dwell_q_nx   = w_dwell_eff;
                    w_sel_nx       = lowest_set(mask);
                    w_cnt_nx       = '0;
                    w_acc_nx       = '0;
                    w_sel_valid_nx = 1'b1;
                    w_busy_nx      = 1'b1;
                end
            end

            ST_DWELL: begin
                if (!en) begin
                    // Abort: partial dwell and partial frame are dropped.
                    w_state_nx = ST_IDLE;
                end else begin
                    w_sel_valid_nx = 1'b1;
                    w_busy_nx      = 1'b1;
                    if (w_last_cycle) begin
                        w_acc_nx        = w_acc_merged;
                        w_sample_stb_nx = 1'b1;
                        w_sample_bit_nx = y;
                        w_sample_ch_nx  = r_sel;
                        if (w_above != '0) begin
                            w_sel_nx = lowest_set(w_above);
                            w_cnt_nx = '0;
                        end else begin
                            w_frame_nx      = w_acc_merged & r_mask_q;
                            w_frame_done_nx = 1'b1;
                            if (single_shot || !w_start_ok) begin
                                w_state_nx     = ST_IDLE;
                                w_sel_valid_nx = 1'b0;
                                w_busy_nx      = 1'b0;
                            end else begin
                                // Free-run: new frame picks up the current mask and dwell.
                                w_mask_q_nx  = mask;
                                w_dwell_q_nx = w_dwell_eff;
                                w_sel_nx     = lowest_set(mask);
                                w_cnt_nx     = '0;
                                w_acc_nx     = '0;
                            end
                        end
                    end else begin
                        w_cnt_nx = r_cnt + DWELL_W'(1);
                    end
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mask_q     <= '0;
            r_dwell_q    <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_sel        <= '0;
            r_sel_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_sample_stb <= 1'b0;
            r_sample_bit <= 1'b0;
            r_sample_ch  <= '0;
            r_frame      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_mask_q     <= w_mask_q_nx;
            r_dwell_q    <= w_dwell_q_nx;
            r_cnt        <= w_cnt_nx;
            r_acc        <= w_acc_nx;
            r_sel        <= w_sel_nx;
            r_sel_valid  <= w_sel_valid_nx;
            r_busy       <= w_busy_nx;
            r_sample_stb <= w_sample_stb_nx;
            r_sample_bit <= w_sample_bit_nx;
            r_sample_ch  <= w_sample_ch_nx;
            r_frame      <= w_frame_nx;
            r_frame_done <= w_frame_done_nx;
        end
    end

    assign sel        = r_sel;
    assign sel_valid  = r_sel_valid;
    assign busy       = r_busy;
    assign sample_stb = r_sample_stb;
    assign sample_bit = r_sample_bit;
    assign sample_ch  = r_sample_ch;
    assign frame      = r_frame;
    assign frame_done = r_frame_done;

endmodule
